// File: rtl/led_blink_bank.sv
// Bank of NCH independent LED blinkers (off / on / blink / one-shot) on a shared prescaled tick.
// Define BLINK_ONESHOT_EN to make mode 11 a one-shot; otherwise mode 11 behaves as blink.
module led_blink_bank #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned CNT_W    = 26,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ack,
    input  logic             sync,
    output logic [NCH-1:0]   led,
    output logic [NCH-1:0]   wrap
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_t;

    logic [PRE_W-1:0] pre_cnt, pre_cnt_nxt;
    logic             tick;
    logic             ch_valid;
    logic [CNT_W-1:0] half_wr;

    mode_t            mode_q [NCH];
    mode_t            mode_d [NCH];
    logic [CNT_W-1:0] half_q [NCH];
    logic [CNT_W-1:0] half_d [NCH];
    logic [CNT_W-1:0] cnt_q  [NCH];
    logic [CNT_W-1:0] cnt_d  [NCH];
    logic [NCH-1:0]   led_d;
    logic [NCH-1:0]   wrap_d;

    assign tick     = (pre_cnt == PRE_W'(PRESCALE - 1));
    assign ch_valid = (32'(cfg_ch) < NCH);
    assign half_wr  = (cfg_half == '0) ? CNT_W'(1) : cfg_half;

    // Per-channel priority: a write to the channel, then sync, then the tick.
    always_comb begin
        pre_cnt_nxt = (sync || tick) ? '0 : pre_cnt + PRE_W'(1);
        for (int unsigned i = 0; i < NCH; i++) begin
            mode_d[i] = mode_q[i];
            half_d[i] = half_q[i];
            cnt_d[i]  = cnt_q[i];
            led_d[i]  = led[i];
            wrap_d[i] = 1'b0;
            if (cfg_we && ch_valid && (32'(cfg_ch) == i)) begin
                mode_d[i] = mode_t'(cfg_mode);
                half_d[i] = half_wr;
                cnt_d[i]  = '0;
                led_d[i]  = (cfg_mode != MODE_OFF);
            end else if (sync) begin
                cnt_d[i] = '0;
                if (mode_q[i] == MODE_BLINK || mode_q[i] == MODE_ONESHOT)
                    led_d[i] = 1'b1;
            end else if (tick) begin
                case (mode_q[i])
`ifdef BLINK_ONESHOT_EN
                    MODE_BLINK: begin
                        if (cnt_q[i] == half_q[i] - CNT_W'(1)) begin
                            cnt_d[i]  = '0;
                            led_d[i]  = ~led[i];
                            wrap_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    MODE_ONESHOT: begin
                        if (cnt_q[i] == half_q[i] - CNT_W'(1)) begin
                            cnt_d[i]  = '0;
                            led_d[i]  = 1'b0;
                            mode_d[i] = MODE_OFF;
                            wrap_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
`else
                    MODE_BLINK, MODE_ONESHOT: begin
                        if (cnt_q[i] == half_q[i] - CNT_W'(1)) begin
                            cnt_d[i]  = '0;
                            led_d[i]  = ~led[i];
                            wrap_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
`endif
                    default: cnt_d[i] = '0;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pre_cnt <= '0;
            cfg_ack <= 1'b0;
            led     <= '0;
            wrap    <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                mode_q[i] <= MODE_OFF;
                half_q[i] <= CNT_W'(1);
                cnt_q[i]  <= '0;
            end
        end else begin
            pre_cnt <= pre_cnt_nxt;
            cfg_ack <= cfg_we;
            led     <= led_d;
            wrap    <= wrap_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                mode_q[i] <= mode_d[i];
                half_q[i] <= half_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

endmodule
